// File: rtl/axicb_default_slv.sv
// AXI4 default slave: terminates unmapped transactions with a fixed error response
// and keeps saturating counts of completed write and read bursts.
module axicb_default_slv #(
   parameter int          AXI_ID_W   = 8,
   parameter int          AXI_DATA_W = 8,
   parameter logic [1:0]  RESP_CODE  = 2'd3,
   parameter logic [63:0] RDATA_FILL = 64'd0,
   parameter int          CNT_W      = 16
) (
   input  logic                  aclk,
   input  logic                  areset,
   input  logic                  i_awvalid,
   output logic                  o_awready,
   input  logic [AXI_ID_W-1:0]   i_awid,
   input  logic                  i_wvalid,
   output logic                  o_wready,
   input  logic                  i_wlast,
   output logic                  o_bvalid,
   input  logic                  i_bready,
   output logic [AXI_ID_W-1:0]   o_bid,
   output logic [1:0]            o_bresp,
   input  logic                  i_arvalid,
   output logic                  o_arready,
   input  logic [AXI_ID_W-1:0]   i_arid,
   input  logic [7:0]            i_arlen,
   output logic                  o_rvalid,
   input  logic                  i_rready,
   output logic [AXI_ID_W-1:0]   o_rid,
   output logic [AXI_DATA_W-1:0] o_rdata,
   output logic [1:0]            o_rresp,
   output logic                  o_rlast,
   output logic [CNT_W-1:0]      o_wr_err_cnt,
   output logic [CNT_W-1:0]      o_rd_err_cnt
);

   typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} w_state_t;
   typedef enum logic       {R_IDLE = 1'b0, R_DATA = 1'b1} r_state_t;

   localparam logic [AXI_DATA_W-1:0] FILL = AXI_DATA_W'(RDATA_FILL);

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      sat_inc = (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
   endfunction

   w_state_t              w_state_r, w_next_s;
   r_state_t              r_state_r, r_next_s;
   logic                  awready_r, wready_r, bvalid_r;
   logic                  arready_r, rvalid_r, rlast_r;
   logic [AXI_ID_W-1:0]   bid_r, rid_r;
   logic [7:0]            beat_cnt_r, beat_cnt_s;
   logic [CNT_W-1:0]      wr_cnt_r, rd_cnt_r;
   logic                  aw_hs_s, w_hs_s, b_hs_s, ar_hs_s, r_hs_s;

   assign aw_hs_s = i_awvalid & awready_r;
   assign w_hs_s  = i_wvalid  & wready_r;
   assign b_hs_s  = bvalid_r  & i_bready;
   assign ar_hs_s = i_arvalid & arready_r;
   assign r_hs_s  = rvalid_r  & i_rready;

   // Write FSM next-state decode
   always_comb begin
      w_next_s = w_state_r;
      case (w_state_r)
         W_IDLE: if (aw_hs_s) w_next_s = W_DATA; else w_next_s = W_IDLE;
         W_DATA: if (w_hs_s && i_wlast) w_next_s = W_RESP; else w_next_s = W_DATA;
         W_RESP: if (b_hs_s) w_next_s = W_IDLE; else w_next_s = W_RESP;
         default: w_next_s = W_IDLE;
      endcase
   end

   // Write state, handshake outputs derived from the next state, BID capture and count
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         w_state_r <= W_IDLE;
         awready_r <= 1'b0;
         wready_r  <= 1'b0;
         bvalid_r  <= 1'b0;
         bid_r     <= '0;
         wr_cnt_r  <= '0;
      end else begin
         w_state_r <= w_next_s;
         awready_r <= (w_next_s == W_IDLE);
         wready_r  <= (w_next_s == W_DATA);
         bvalid_r  <= (w_next_s == W_RESP);
         if (aw_hs_s) bid_r <= i_awid;
         if (b_hs_s) wr_cnt_r <= sat_inc(wr_cnt_r);
      end
   end

   // Read FSM next-state and remaining-beat counter; counter holds beats left minus one
   always_comb begin
      r_next_s   = r_state_r;
      beat_cnt_s = beat_cnt_r;
      case (r_state_r)
         R_IDLE: begin
            if (ar_hs_s) begin
               r_next_s   = R_DATA;
               beat_cnt_s = i_arlen;
            end else begin
               r_next_s   = R_IDLE;
               beat_cnt_s = beat_cnt_r;
            end
         end
         R_DATA: begin
            if (r_hs_s && (beat_cnt_r == 8'd0)) begin
               r_next_s   = R_IDLE;
               beat_cnt_s = beat_cnt_r;
            end else if (r_hs_s) begin
               r_next_s   = R_DATA;
               beat_cnt_s = beat_cnt_r - 8'd1;
            end else begin
               r_next_s   = R_DATA;
               beat_cnt_s = beat_cnt_r;
            end
         end
         default: begin
            r_next_s   = R_IDLE;
            beat_cnt_s = 8'd0;
         end
      endcase
   end

   // Read state, registered R channel controls, RID capture and count
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         r_state_r  <= R_IDLE;
         beat_cnt_r <= 8'd0;
         arready_r  <= 1'b0;
         rvalid_r   <= 1'b0;
         rlast_r    <= 1'b0;
         rid_r      <= '0;
         rd_cnt_r   <= '0;
      end else begin
         r_state_r  <= r_next_s;
         beat_cnt_r <= beat_cnt_s;
         arready_r  <= (r_next_s == R_IDLE);
         rvalid_r   <= (r_next_s == R_DATA);
         rlast_r    <= (r_next_s == R_DATA) && (beat_cnt_s == 8'd0);
         if (ar_hs_s) rid_r <= i_arid;
         if (r_hs_s && rlast_r) rd_cnt_r <= sat_inc(rd_cnt_r);
      end
   end

   assign o_awready    = awready_r;
   assign o_wready     = wready_r;
   assign o_bvalid     = bvalid_r;
   assign o_bid        = bid_r;
   assign o_bresp      = RESP_CODE;
   assign o_arready    = arready_r;
   assign o_rvalid     = rvalid_r;
   assign o_rid        = rid_r;
   assign o_rdata      = FILL;
   assign o_rresp      = RESP_CODE;
   assign o_rlast      = rlast_r;
   assign o_wr_err_cnt = wr_cnt_r;
   assign o_rd_err_cnt = rd_cnt_r;

endmodule

// File: tb/tb_axicb_default_slv.sv
// Randomized self-checking bench for axicb_default_slv with a burst-level
// reference model (beats sent/received, address accepted, expected counts).
module tb_axicb_default_slv;
   localparam logic [1:0] RESP     = 2'd3;
   localparam logic [7:0] FILL_EXP = 8'hA5;

   logic aclk = 1'b0;
   logic areset = 1'b1;
   always #5 aclk = ~aclk;

   logic i_awvalid = 1'b0, i_wvalid = 1'b0, i_wlast = 1'b0, i_bready = 1'b0;
   logic i_arvalid = 1'b0, i_rready = 1'b0;
   logic [7:0] i_awid = 8'd0, i_arid = 8'd0, i_arlen = 8'd0;
   logic o_awready, o_wready, o_bvalid, o_arready, o_rvalid, o_rlast;
   logic [7:0] o_bid, o_rid, o_rdata;
   logic [1:0] o_bresp, o_rresp;
   logic [15:0] o_wr_err_cnt, o_rd_err_cnt;

   logic s_awvalid = 1'b0, s_wvalid = 1'b0, s_bready = 1'b0;
   logic s_awready, s_wready, s_bvalid, s_arready, s_rvalid, s_rlast;
   logic [7:0] s_bid, s_rid, s_rdata;
   logic [1:0] s_bresp, s_rresp, s_wr_cnt, s_rd_cnt;

   int errors = 0;
   int checks = 0;
   int exp_wr = 0;
   int exp_rd = 0;

   axicb_default_slv #(.AXI_ID_W(8), .AXI_DATA_W(8), .RESP_CODE(2'd3),
                       .RDATA_FILL(64'h1A5), .CNT_W(16)) u_dut (
      .aclk(aclk), .areset(areset),
      .i_awvalid(i_awvalid), .o_awready(o_awready), .i_awid(i_awid),
      .i_wvalid(i_wvalid), .o_wready(o_wready), .i_wlast(i_wlast),
      .o_bvalid(o_bvalid), .i_bready(i_bready), .o_bid(o_bid), .o_bresp(o_bresp),
      .i_arvalid(i_arvalid), .o_arready(o_arready), .i_arid(i_arid), .i_arlen(i_arlen),
      .o_rvalid(o_rvalid), .i_rready(i_rready), .o_rid(o_rid), .o_rdata(o_rdata),
      .o_rresp(o_rresp), .o_rlast(o_rlast),
      .o_wr_err_cnt(o_wr_err_cnt), .o_rd_err_cnt(o_rd_err_cnt));

   axicb_default_slv #(.AXI_ID_W(8), .AXI_DATA_W(8), .RESP_CODE(2'd3),
                       .RDATA_FILL(64'h0), .CNT_W(2)) u_sat (
      .aclk(aclk), .areset(areset),
      .i_awvalid(s_awvalid), .o_awready(s_awready), .i_awid(8'h07),
      .i_wvalid(s_wvalid), .o_wready(s_wready), .i_wlast(1'b1),
      .o_bvalid(s_bvalid), .i_bready(s_bready), .o_bid(s_bid), .o_bresp(s_bresp),
      .i_arvalid(1'b0), .o_arready(s_arready), .i_arid(8'h00), .i_arlen(8'h00),
      .o_rvalid(s_rvalid), .i_rready(1'b0), .o_rid(s_rid), .o_rdata(s_rdata),
      .o_rresp(s_rresp), .o_rlast(s_rlast),
      .o_wr_err_cnt(s_wr_cnt), .o_rd_err_cnt(s_rd_cnt));

   task automatic test_reset();
      areset = 1'b1;
      repeat (2) @(negedge aclk);
      checks++;
      if ({o_awready, o_wready, o_bvalid, o_arready, o_rvalid, o_rlast} !== 6'b0) begin
         errors++;
         $display("FAIL reset_ctrl: got %b exp 000000",
                  {o_awready, o_wready, o_bvalid, o_arready, o_rvalid, o_rlast});
      end
      checks++;
      if ({o_bid, o_rid, o_wr_err_cnt, o_rd_err_cnt} !== 48'd0) begin
         errors++;
         $display("FAIL reset_data: bid=%h rid=%h wcnt=%0d rcnt=%0d exp all 0",
                  o_bid, o_rid, o_wr_err_cnt, o_rd_err_cnt);
      end
      areset = 1'b0;
      @(negedge aclk);
      checks++;
      if (o_awready !== 1'b1 || o_arready !== 1'b1 || o_wready !== 1'b0 || o_rvalid !== 1'b0) begin
         errors++;
         $display("FAIL post_reset: awready=%b arready=%b wready=%b rvalid=%b exp 1 1 0 0",
                  o_awready, o_arready, o_wready, o_rvalid);
      end
   endtask

   task automatic test_single_write();
      i_awvalid = 1'b1; i_awid = 8'h12;
      @(negedge aclk);
      checks++;
      if (o_awready !== 1'b0 || o_wready !== 1'b1) begin
         errors++;
         $display("FAIL sw_wready: awready=%b wready=%b exp 0 1", o_awready, o_wready);
      end
      i_awvalid = 1'b0; i_awid = 8'hFF; i_wvalid = 1'b1; i_wlast = 1'b1; i_bready = 1'b1;
      @(negedge aclk);
      checks++;
      if (o_wready !== 1'b0 || o_bvalid !== 1'b1 || o_bid !== 8'h12 || o_bresp !== RESP) begin
         errors++;
         $display("FAIL sw_bresp: wready=%b bvalid=%b bid=%h bresp=%0d exp 0 1 12 3",
                  o_wready, o_bvalid, o_bid, o_bresp);
      end
      i_wvalid = 1'b0; i_wlast = 1'b0;
      @(negedge aclk);
      exp_wr++;
      checks++;
      if (o_bvalid !== 1'b0 || o_awready !== 1'b1 || o_wr_err_cnt !== 16'(exp_wr)) begin
         errors++;
         $display("FAIL sw_done: bvalid=%b awready=%b wcnt=%0d exp 0 1 %0d",
                  o_bvalid, o_awready, o_wr_err_cnt, exp_wr);
      end
      i_bready = 1'b0;
   endtask

   // one write burst driven with random valid/ready gaps, checked cycle by cycle
   task automatic do_write(input logic [7:0] id, input int beats, input int hold);
      bit aw_done = 1'b0;
      bit done = 1'b0;
      bit aw_hs, w_hs, b_hs;
      int sent = 0;
      int b_cyc = 0;
      for (int cyc = 0; cyc < 400 && !done; cyc++) begin
         checks++;
         if (o_awready !== !aw_done || o_wready !== (aw_done && sent < beats) ||
             o_bvalid !== (sent == beats)) begin
            errors++;
            $display("FAIL wr_ctrl: aw/w/b ready-valid=%b%b%b exp %b%b%b (sent %0d of %0d)",
                     o_awready, o_wready, o_bvalid, !aw_done, aw_done && sent < beats,
                     sent == beats, sent, beats);
         end
         checks++;
         if (o_wr_err_cnt !== 16'(exp_wr)) begin
            errors++;
            $display("FAIL wr_cnt: got %0d exp %0d", o_wr_err_cnt, exp_wr);
         end
         if (sent == beats) begin
            checks++;
            if (o_bid !== id || o_bresp !== RESP) begin
               errors++;
               $display("FAIL wr_b: bid=%h bresp=%0d exp %h %0d", o_bid, o_bresp, id, RESP);
            end
         end
         i_awvalid = !aw_done && ($urandom_range(0, 3) != 0);
         i_awid    = aw_done ? 8'($urandom) : id;
         i_wvalid  = (sent < beats) && ($urandom_range(0, 2) != 0);
         i_wlast   = (sent == beats - 1);
         if (sent == beats) begin
            b_cyc++;
            i_bready = (b_cyc > hold) && ($urandom_range(0, 1) == 1);
         end else begin
            i_bready = 1'($urandom_range(0, 1));
         end
         aw_hs = i_awvalid && !aw_done;
         w_hs  = i_wvalid && aw_done && (sent < beats);
         b_hs  = i_bready && (sent == beats);
         @(negedge aclk);
         if (aw_hs) aw_done = 1'b1;
         if (w_hs) sent++;
         if (b_hs) begin
            done = 1'b1;
            exp_wr++;
         end
      end
      checks++;
      if (!done) begin
         errors++;
         $display("FAIL wr_timeout: burst id %h did not complete (sent %0d of %0d)", id, sent, beats);
      end
      i_awvalid = 1'b0; i_wvalid = 1'b0; i_wlast = 1'b0; i_bready = 1'b0;
   endtask

   task automatic test_write_random();
      do_write(8'h5C, 4, 5);
      for (int n = 0; n < 8; n++) do_write(8'($urandom), $urandom_range(1, 6), $urandom_range(0, 3));
   endtask

   // one read burst with random ready gaps; abort_at >= 0 pulses areset after that many beats
   task automatic do_read(input logic [7:0] id, input int arlen, input int abort_at);
      bit ar_done = 1'b0;
      bit done = 1'b0;
      bit ar_hs, r_hs;
      int got = 0;
      int total = arlen + 1;
      for (int cyc = 0; cyc < 2000 && !done; cyc++) begin
         if (abort_at >= 0 && ar_done && got == abort_at) begin
            i_arvalid = 1'b0; i_rready = 1'b0;
            areset = 1'b1;
            #1;
            checks++;
            if (o_rvalid !== 1'b0 || o_rlast !== 1'b0 || o_arready !== 1'b0 || o_rd_err_cnt !== 16'd0) begin
               errors++;
               $display("FAIL rd_abort: rvalid=%b rlast=%b arready=%b rcnt=%0d exp 0 0 0 0",
                        o_rvalid, o_rlast, o_arready, o_rd_err_cnt);
            end
            exp_wr = 0; exp_rd = 0;
            @(negedge aclk);
            areset = 1'b0;
            done = 1'b1;
            break;
         end
         checks++;
         if (o_arready !== !ar_done || o_rvalid !== ar_done || o_rd_err_cnt !== 16'(exp_rd)) begin
            errors++;
            $display("FAIL rd_ctrl: arready=%b rvalid=%b rcnt=%0d exp %b %b %0d",
                     o_arready, o_rvalid, o_rd_err_cnt, !ar_done, ar_done, exp_rd);
         end
         if (ar_done) begin
            checks++;
            if (o_rid !== id || o_rresp !== RESP || o_rdata !== FILL_EXP ||
                o_rlast !== (total - got == 1)) begin
               errors++;
               $display("FAIL rd_beat%0d: rid=%h rresp=%0d rdata=%h rlast=%b exp %h %0d %h %b",
                        got, o_rid, o_rresp, o_rdata, o_rlast, id, RESP, FILL_EXP, total - got == 1);
            end
         end
         i_arvalid = !ar_done && ($urandom_range(0, 3) != 0);
         i_arid    = ar_done ? 8'($urandom) : id;
         i_arlen   = ar_done ? 8'($urandom) : 8'(arlen);
         i_rready  = 1'($urandom_range(0, 1));
         ar_hs = i_arvalid && !ar_done;
         r_hs  = i_rready && ar_done;
         @(negedge aclk);
         if (ar_hs) ar_done = 1'b1;
         if (r_hs) begin
            got++;
            if (got == total) begin
               done = 1'b1;
               exp_rd++;
            end
         end
      end
      checks++;
      if (!done) begin
         errors++;
         $display("FAIL rd_timeout: burst id %h did not complete (got %0d of %0d)", id, got, total);
      end
      i_arvalid = 1'b0; i_rready = 1'b0;
   endtask

   task automatic test_read_random();
      do_read(8'h21, 3, -1);
      for (int n = 0; n < 8; n++) do_read(8'($urandom), $urandom_range(0, 6), -1);
      do_read(8'hEE, 255, -1);
      do_read(8'h01, 0, -1);
   endtask

   task automatic test_concurrent();
      i_awvalid = 1'b1; i_awid = 8'h44; i_wvalid = 1'b1; i_wlast = 1'b1; i_bready = 1'b1;
      i_arvalid = 1'b1; i_arid = 8'h55; i_arlen = 8'd0; i_rready = 1'b1;
      @(negedge aclk);
      checks++;
      if (o_awready !== 1'b0 || o_arready !== 1'b0 || o_wready !== 1'b1 ||
          o_rvalid !== 1'b1 || o_rlast !== 1'b1 || o_rid !== 8'h55) begin
         errors++;
         $display("FAIL cc_accept: awr=%b arr=%b wr=%b rv=%b rl=%b rid=%h exp 0 0 1 1 1 55",
                  o_awready, o_arready, o_wready, o_rvalid, o_rlast, o_rid);
      end
      i_awvalid = 1'b0; i_arvalid = 1'b0;
      @(negedge aclk);
      exp_rd++;
      checks++;
      if (o_bvalid !== 1'b1 || o_bid !== 8'h44 || o_rvalid !== 1'b0 ||
          o_arready !== 1'b1 || o_rd_err_cnt !== 16'(exp_rd)) begin
         errors++;
         $display("FAIL cc_resp: bvalid=%b bid=%h rvalid=%b arready=%b rcnt=%0d exp 1 44 0 1 %0d",
                  o_bvalid, o_bid, o_rvalid, o_arready, o_rd_err_cnt, exp_rd);
      end
      i_wvalid = 1'b0; i_wlast = 1'b0;
      @(negedge aclk);
      exp_wr++;
      checks++;
      if (o_bvalid !== 1'b0 || o_awready !== 1'b1 || o_wr_err_cnt !== 16'(exp_wr)) begin
         errors++;
         $display("FAIL cc_done: bvalid=%b awready=%b wcnt=%0d exp 0 1 %0d",
                  o_bvalid, o_awready, o_wr_err_cnt, exp_wr);
      end
      i_bready = 1'b0; i_rready = 1'b0;
   endtask

   task automatic test_saturation();
      int sat_exp = 0;
      for (int k = 1; k <= 5; k++) begin
         s_awvalid = 1'b1;
         @(negedge aclk);
         s_awvalid = 1'b0; s_wvalid = 1'b1;
         @(negedge aclk);
         s_wvalid = 1'b0; s_bready = 1'b1;
         @(negedge aclk);
         s_bready = 1'b0;
         sat_exp = (sat_exp == 3) ? 3 : sat_exp + 1;
         checks++;
         if (s_wr_cnt !== 2'(sat_exp) || s_awready !== 1'b1) begin
            errors++;
            $display("FAIL sat_write%0d: cnt=%0d awready=%b exp %0d 1", k, s_wr_cnt, s_awready, sat_exp);
         end
      end
   endtask

   task automatic test_reset_mid_burst();
      do_read(8'h77, 7, 2);
      @(negedge aclk);
      checks++;
      if (o_arready !== 1'b1 || o_awready !== 1'b1 || o_rvalid !== 1'b0) begin
         errors++;
         $display("FAIL rst_mid_idle: arready=%b awready=%b rvalid=%b exp 1 1 0",
                  o_arready, o_awready, o_rvalid);
      end
      do_read(8'h3C, 3, -1);
      checks++;
      if (o_rd_err_cnt !== 16'(exp_rd) || o_wr_err_cnt !== 16'(exp_wr)) begin
         errors++;
         $display("FAIL rst_mid_cnt: rcnt=%0d wcnt=%0d exp %0d %0d",
                  o_rd_err_cnt, o_wr_err_cnt, exp_rd, exp_wr);
      end
   endtask

   initial begin
      test_reset();
      test_single_write();
      test_write_random();
      test_read_random();
      test_concurrent();
      test_saturation();
      test_reset_mid_burst();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
